// File: rtl/multicycle_core_top.sv
// multicycle_core_top
//   Multi-cycle RV integer core. Instructions come in over a valid/ready
//   request with an rvalid response. The core runs ADDI/ADD/SUB/LUI/AUIPC/
//   JAL/JALR and stops on EBREAK (capturing a0) or on anything it cannot
//   execute.
//   Ports:
//     clk, rst                  clock; asynchronous active-low reset
//     imem_req/imem_addr        fetch request; the address is the current pc
//     imem_ready                request accepted when imem_req && imem_ready
//     imem_rvalid/imem_rdata    instruction response, sampled only in WAIT
//     pc                        pc of the instruction being fetched/executed
//     retire                    combinational pulse in EXEC of a legal instruction
//     halt/illegal/halt_code    sticky stop status; halt_code holds x10 at EBREAK
module multicycle_core_top #(
  parameter int              XLEN     = 64,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = 'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] pc,
  output logic            retire,
  output logic            halt,
  output logic            illegal,
  output logic [XLEN-1:0] halt_code
);

  localparam int              IDXW    = $clog2(NREGS);
  localparam logic [XLEN-1:0] FOUR    = XLEN'(4);
  localparam logic [XLEN-1:0] ONE     = XLEN'(1);
  localparam logic [31:0]     EBREAK  = 32'h0010_0073;
  localparam logic [6:0]      OP_IMM  = 7'b0010011;
  localparam logic [6:0]      OP_REG  = 7'b0110011;
  localparam logic [6:0]      OP_LUI  = 7'b0110111;
  localparam logic [6:0]      OP_AUI  = 7'b0010111;
  localparam logic [6:0]      OP_JAL  = 7'b1101111;
  localparam logic [6:0]      OP_JALR = 7'b1100111;

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_EXEC, S_HALT} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     inst_q;
  logic            illegal_q;
  logic [XLEN-1:0] halt_code_q;
  logic [XLEN-1:0] gpr [NREGS];

  function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  function automatic logic idx_ok(input logic [4:0] idx);
    return int'(idx) < NREGS;
  endfunction

  // decode fields
  logic [6:0] opcode, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  assign opcode = inst_q[6:0];
  assign rd     = inst_q[11:7];
  assign f3     = inst_q[14:12];
  assign rs1    = inst_q[19:15];
  assign rs2    = inst_q[24:20];
  assign f7     = inst_q[31:25];

  logic [XLEN-1:0] imm_i, imm_u, imm_j;
  assign imm_i = sext({{20{inst_q[31]}}, inst_q[31:20]});
  assign imm_u = sext({inst_q[31:12], 12'b0});
  assign imm_j = sext({{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20],
                       inst_q[30:21], 1'b0});

  // out-of-range indices read as zero; such instructions are flagged illegal anyway
  logic [XLEN-1:0] rs1_val, rs2_val, x10_val;
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != 5'd0 && idx_ok(rs1)) rs1_val = gpr[rs1[IDXW-1:0]];
    if (rs2 != 5'd0 && idx_ok(rs2)) rs2_val = gpr[rs2[IDXW-1:0]];
    x10_val = gpr[10];
  end

  // execute: everything computed from the latched inst and pre-write GPRs
  logic            legal, wr, is_ebreak;
  logic [XLEN-1:0] wdata, next_pc, tgt;
  always_comb begin
    legal     = 1'b0;
    wr        = 1'b0;
    wdata     = '0;
    next_pc   = pc_q + FOUR;
    tgt       = '0;
    is_ebreak = (inst_q == EBREAK);
    case (opcode)
      OP_IMM: begin
        legal = (f3 == 3'd0) && idx_ok(rd) && idx_ok(rs1);
        wr    = 1'b1;
        wdata = rs1_val + imm_i;
      end
      OP_REG: begin
        legal = (f3 == 3'd0) && (f7 == 7'h00 || f7 == 7'h20) &&
                idx_ok(rd) && idx_ok(rs1) && idx_ok(rs2);
        wr    = 1'b1;
        wdata = f7[5] ? rs1_val - rs2_val : rs1_val + rs2_val;
      end
      OP_LUI: begin
        legal = idx_ok(rd);
        wr    = 1'b1;
        wdata = imm_u;
      end
      OP_AUI: begin
        legal = idx_ok(rd);
        wr    = 1'b1;
        wdata = pc_q + imm_u;
      end
      OP_JAL: begin
        tgt     = pc_q + imm_j;
        legal   = idx_ok(rd) && !tgt[1];
        wr      = 1'b1;
        wdata   = pc_q + FOUR;
        next_pc = tgt;
      end
      OP_JALR: begin
        tgt     = (rs1_val + imm_i) & ~ONE;
        legal   = (f3 == 3'd0) && idx_ok(rd) && idx_ok(rs1) && !tgt[1];
        wr      = 1'b1;
        wdata   = pc_q + FOUR;
        next_pc = tgt;
      end
      default: legal = is_ebreak;
    endcase
    wr = wr && legal && (rd != 5'd0);
  end

  // FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: if (imem_ready) state_d = S_WAIT;
      S_WAIT:  if (imem_rvalid) state_d = S_EXEC;
      S_EXEC: begin
        retire  = legal;
        state_d = (legal && !is_ebreak) ? S_FETCH : S_HALT;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q        <= RESET_PC;
      inst_q      <= '0;
      illegal_q   <= 1'b0;
      halt_code_q <= '0;
    end else begin
      if (state_q == S_WAIT && imem_rvalid) inst_q <= imem_rdata;
      if (state_q == S_EXEC) begin
        if (legal && !is_ebreak) pc_q <= next_pc;
        if (!legal)              illegal_q <= 1'b1;
        if (is_ebreak)           halt_code_q <= x10_val;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) gpr[i] <= '0;
    end else if (state_q == S_EXEC && wr) begin
      gpr[rd[IDXW-1:0]] <= wdata;
    end
  end

  // request is suppressed while reset is held so nothing is issued mid-reset
  assign imem_req  = (state_q == S_FETCH) && rst;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign halt      = (state_q == S_HALT);
  assign illegal   = illegal_q;
  assign halt_code = halt_code_q;

endmodule
